// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scans four 4-bit signed sources onto an 8-digit common-anode
// multiplexed display through one shared external sign/magnitude decoder.
// Each source owns two consecutive digit slots: its sign digit first, then its
// magnitude digit. The sources are snapshotted once per frame, at the slot 7
// to slot 0 wrap. Each slot opens with BLANK cycles of all anodes off, which
// suppresses ghosting when the decoder output changes.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   src0..3   signed sources; srck is shown on slots 2k (sign) and 2k+1 (magnitude)
//   en        per-source enable; en[k]=0 blanks both digits of source k
//   hold      when high at the wrap edge, the snapshot keeps its old value
//   dec_nib   nibble sent to the external decoder (combinational, from the snapshot)
//   dec_seg   decoder return, active-low {a1..g1 (sign), a2..g2 (magnitude)}
//   seg       registered active-low segments {a..g}
//   an        registered active-low anodes; an[i] selects slot i
//   frame     one-cycle pulse on the first cycle of slot 0
module seg_scan_ctrl #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned BLANK    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  src0,
    input  logic [3:0]  src1,
    input  logic [3:0]  src2,
    input  logic [3:0]  src3,
    input  logic [3:0]  en,
    input  logic        hold,
    output logic [3:0]  dec_nib,
    input  logic [13:0] dec_seg,
    output logic [6:0]  seg,
    output logic [7:0]  an,
    output logic        frame
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK);
    localparam logic [7:0]       AN_OFF    = 8'hFF;
    localparam logic [6:0]       SEG_OFF   = 7'h7F;

    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       slot_q,  slot_d;
    logic [3:0][3:0]  snap_q,  snap_d;
    logic             frame_q, frame_d;
    logic [7:0]       an_q,    an_d;
    logic [6:0]       seg_q,   seg_d;

    logic             slot_end;
    logic             wrap;
    logic             in_blank;
    logic             src_on;
    logic [1:0]       src_idx;

    // Decoder request: the source that owns the current slot pair
    assign src_idx = slot_q[2:1];
    assign dec_nib = snap_q[src_idx];

    // Refresh counter, slot stepping and frame-boundary snapshot
    always_comb begin
        cnt_d    = cnt_q;
        slot_d   = slot_q;
        snap_d   = snap_q;
        frame_d  = 1'b0;
        slot_end = (cnt_q == CNT_LAST);
        wrap     = slot_end && (slot_q == 3'd7);

        if (slot_end) begin
            cnt_d  = '0;
            slot_d = slot_q + 3'd1;
        end else begin
            cnt_d  = cnt_q + CNT_W'(1);
        end

        if (wrap) begin
            frame_d = 1'b1;
            if (!hold) begin
                snap_d = {src3, src2, src1, src0};
            end
        end
    end

    // Output staging: blank at slot start or for disabled sources; the decoder
    // result is captured in the same cycle the nibble is presented.
    always_comb begin
        an_d     = AN_OFF;
        seg_d    = SEG_OFF;
        in_blank = (cnt_q < BLANK_END);
        src_on   = en[src_idx];

        if (!in_blank && src_on) begin
            an_d  = ~(8'b1 << slot_q);
            seg_d = slot_q[0] ? dec_seg[6:0] : dec_seg[13:7];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            slot_q  <= 3'd0;
            snap_q  <= '0;
            frame_q <= 1'b0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
        end else begin
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            snap_q  <= snap_d;
            frame_q <= frame_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (BLANK=1 and BLANK=2, PRESCALE=4)
// share all stimulus. A reference model derives each cycle's expected outputs
// from the elapsed cycle count and pushes them into per-instance queues; a
// negedge monitor pops and compares.
module tb_seg_scan_ctrl;

    localparam int unsigned P  = 4;
    localparam int unsigned BA = 1;
    localparam int unsigned BB = 2;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       frame;
        logic [3:0] nib;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src0, src1, src2, src3;
    logic [3:0]  en;
    logic        hold;

    logic [3:0]  nib_a,   nib_b;
    logic [13:0] dseg_a,  dseg_b;
    logic [6:0]  seg_a,   seg_b;
    logic [7:0]  an_a,    an_b;
    logic        frame_a, frame_b;

    exp_t        qa[$];
    exp_t        qb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n;
    logic [3:0]  m_snap [4];

    always #5 clk = ~clk;

    seg_scan_ctrl #(.PRESCALE(P), .BLANK(BA)) u_dut_a (
        .clk(clk), .rst(rst), .src0(src0), .src1(src1), .src2(src2), .src3(src3),
        .en(en), .hold(hold), .dec_nib(nib_a), .dec_seg(dseg_a),
        .seg(seg_a), .an(an_a), .frame(frame_a)
    );

    seg_scan_ctrl #(.PRESCALE(P), .BLANK(BB)) u_dut_b (
        .clk(clk), .rst(rst), .src0(src0), .src1(src1), .src2(src2), .src3(src3),
        .en(en), .hold(hold), .dec_nib(nib_b), .dec_seg(dseg_b),
        .seg(seg_b), .an(an_b), .frame(frame_b)
    );

    // Active-low sign digit: only segment g lit for negative values
    function automatic logic [6:0] sign_dig(input logic [3:0] v);
        return v[3] ? 7'b1111110 : 7'h7F;
    endfunction

    // Active-low magnitude digit {a..g}
    function automatic logic [6:0] mag_dig(input logic [3:0] v);
        int m;
        m = v[3] ? 16 - int'(v) : int'(v);
        case (m)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            default: return 7'h7F;
        endcase
    endfunction

    // External shared decoders
    always_comb dseg_a = {sign_dig(nib_a), mag_dig(nib_a)};
    always_comb dseg_b = {sign_dig(nib_b), mag_dig(nib_b)};

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endfunction

    function automatic exp_t expect_for(input int unsigned b);
        exp_t e;
        int   slot;
        int   ph;
        slot = (n / P) % 8;
        ph   = n % P;
        e    = '0;
        if (ph < b || !en[slot / 2]) begin
            e.an  = 8'hFF;
            e.seg = 7'h7F;
        end else begin
            e.an  = ~(8'(1) << slot);
            e.seg = (slot % 2 == 0) ? sign_dig(m_snap[slot / 2]) : mag_dig(m_snap[slot / 2]);
        end
        e.frame = (ph == P - 1) && (slot == 7);
        return e;
    endfunction

    // Reference model for one rising edge; n counts edges since reset release
    task automatic model_edge();
        exp_t ea;
        exp_t eb;
        ea = expect_for(BA);
        eb = expect_for(BB);
        if (ea.frame && !hold) begin
            m_snap[0] = src0; m_snap[1] = src1; m_snap[2] = src2; m_snap[3] = src3;
        end
        n++;
        ea.nib = m_snap[((n / P) % 8) / 2];
        eb.nib = ea.nib;
        qa.push_back(ea);
        qb.push_back(eb);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) cycle();
    endtask

    task automatic align(input int target);
        for (int i = 0; i < 64 && (n % 32) != target; i++) cycle();
        check("align", 32'(n % 32), 32'(target));
    endtask

    task automatic check_reset_outputs();
        check("rst_an_a",    32'(an_a),    32'h0FF);
        check("rst_seg_a",   32'(seg_a),   32'h07F);
        check("rst_frame_a", 32'(frame_a), 32'h0);
        check("rst_nib_a",   32'(nib_a),   32'h0);
        check("rst_an_b",    32'(an_b),    32'h0FF);
        check("rst_seg_b",   32'(seg_b),   32'h07F);
        check("rst_frame_b", 32'(frame_b), 32'h0);
        check("rst_nib_b",   32'(nib_b),   32'h0);
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        exp_t e;
        if (!rst && qa.size() > 0) begin
            e = qa.pop_front();
            check("a_an",    32'(an_a),    32'(e.an));
            check("a_seg",   32'(seg_a),   32'(e.seg));
            check("a_frame", 32'(frame_a), 32'(e.frame));
            check("a_nib",   32'(nib_a),   32'(e.nib));
            check("a_one_anode", 32'($countones(~an_a) <= 1), 32'h1);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && qb.size() > 0) begin
            e = qb.pop_front();
            check("b_an",    32'(an_b),    32'(e.an));
            check("b_seg",   32'(seg_b),   32'(e.seg));
            check("b_frame", 32'(frame_b), 32'(e.frame));
            check("b_nib",   32'(nib_b),   32'(e.nib));
            check("b_one_anode", 32'($countones(~an_b) <= 1), 32'h1);
        end
    end

    initial begin
        rst  = 1'b1;
        en   = 4'h0;
        hold = 1'b0;
        src0 = 4'h0; src1 = 4'h0; src2 = 4'h0; src3 = 4'h0;
        n    = 0;
        for (int k = 0; k < 4; k++) m_snap[k] = 4'h0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();

        // Scan order: first frame shows zeros, then src3..src0 = {3,-1,-8,0}
        rst  = 1'b0;
        en   = 4'hF;
        src0 = 4'h0; src1 = 4'h8; src2 = 4'hF; src3 = 4'h3;
        run(64);

        // Snapshot: change mid-frame, visible only after the wrap
        src0 = 4'h3;
        align(0);
        run(16);
        src0 = 4'h5;
        run(48);

        // Hold across the wrap keeps the old snapshot
        src0 = 4'h3;
        align(0);
        run(16);
        src0 = 4'h5;
        hold = 1'b1;
        run(40);
        hold = 1'b0;
        run(40);

        // Enable mask
        en = 4'b1010;
        run(40);
        en = 4'hF;

        // Mid-slot disable during slot 3 drive phase
        align(14);
        en[1] = 1'b0;
        run(8);
        en = 4'hF;

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(15) == 0) begin
                src0 = 4'($urandom); src1 = 4'($urandom);
                src2 = 4'($urandom); src3 = 4'($urandom);
            end
            if ($urandom_range(31) == 0) hold = ~hold;
            if ($urandom_range(23) == 0) en = 4'($urandom);
            cycle();
        end

        // Reset mid-drive
        en   = 4'hF;
        hold = 1'b0;
        for (int i = 0; i < 8 && (n % P) != 2; i++) cycle();
        rst = 1'b1;
        #1;
        check_reset_outputs();
        qa.delete();
        qb.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        n   = 0;
        for (int k = 0; k < 4; k++) m_snap[k] = 4'h0;
        run(80);

        // Drain
        for (int i = 0; i < 4 && (qa.size() > 0 || qb.size() > 0); i++) @(posedge clk);
        @(negedge clk);
        #1;
        check("drain_qa", 32'(qa.size()), 32'h0);
        check("drain_qb", 32'(qb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
